// File: rtl/lcd_byte_writer.sv
// Writes one byte to an HD44780-style LCD per custom instruction: drives the RS/E/DATA
// timing sequence, waits out the controller execution time, then pulses done.
module lcd_byte_writer #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 12,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned CLEAR_CYC = 80000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        lcd_enable,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data
);

  // A zero cycle count is treated as one cycle, so the load value is max(n,1)-1.
  function automatic logic [CNT_W-1:0] load_val(input int unsigned n);
    return (n == 0) ? '0 : CNT_W'(n - 1);
  endfunction

  localparam logic [CNT_W-1:0] LD_SETUP = load_val(SETUP_CYC);
  localparam logic [CNT_W-1:0] LD_PULSE = load_val(PULSE_CYC);
  localparam logic [CNT_W-1:0] LD_HOLD  = load_val(HOLD_CYC);
  localparam logic [CNT_W-1:0] LD_EXEC  = load_val(EXEC_CYC);
  localparam logic [CNT_W-1:0] LD_CLEAR = load_val(CLEAR_CYC);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               long_q, long_d;
  logic [7:0]         data_q, data_d;
  logic               rs_q, rs_d;
  logic               enable_q, enable_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;

  logic unused_bits;
  assign unused_bits = ^{dataa[31:8], datab[31:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    long_d   = long_q;
    data_d   = data_q;
    rs_d     = rs_q;
    enable_d = enable_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = dataa[7:0];
          rs_d    = datab[0];
          // Clear Display / Return Home need the long execution wait.
          long_d  = ~datab[0] && (dataa[7:0] inside {8'h01, 8'h02, 8'h03});
          cnt_d   = LD_SETUP;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          enable_d = 1'b1;
          cnt_d    = LD_PULSE;
          state_d  = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          enable_d = 1'b0;
          cnt_d    = LD_HOLD;
          state_d  = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = long_q ? LD_CLEAR : LD_EXEC;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          done_d   = 1'b1;
          result_d = {23'd0, rs_q, data_q};
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        enable_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      long_q   <= 1'b0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      long_q   <= long_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign result     = result_q;
  assign done       = done_q;
  assign lcd_enable = enable_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_data   = data_q;

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Directed bench for lcd_byte_writer with short timing parameters
// (SETUP=2, PULSE=4, HOLD=1, EXEC=8, CLEAR=20).
module tb_lcd_byte_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;
  logic        lcd_enable;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_byte_writer #(
    .SETUP_CYC(2),
    .PULSE_CYC(4),
    .HOLD_CYC (1),
    .EXEC_CYC (8),
    .CLEAR_CYC(20),
    .CNT_W    (17)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .dataa     (dataa),
    .datab     (datab),
    .result    (result),
    .done      (done),
    .lcd_enable(lcd_enable),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One write, observed for a fixed 45-edge window after the sampling edge k.
  // Indices are edges after k; outputs are sampled 1 ns after each edge.
  task automatic run_write(input string tag, input logic [7:0] b, input logic rs,
                           input int exp_done, input int exp_ehigh,
                           input int busy1, input int busy2,
                           input int stall_at, input int stall_len);
    int e_rise   = -1;
    int e_high   = 0;
    int done_idx = -1;
    int done_cnt = 0;
    int bad_data = 0;
    int bad_rw   = 0;
    logic [31:0] res_at_done = 'x;
    start  = 1'b1;
    dataa  = {24'hABCDEF, b};
    datab  = {31'h7FFF_FFFE >> 1, rs};
    clk_en = 1'b1;
    tick();
    for (int i = 1; i <= 45; i++) begin
      if (lcd_data !== b || lcd_rs !== rs) bad_data++;
      if (lcd_rw !== 1'b0) bad_rw++;
      start  = (i == busy1 || i == busy2);
      dataa  = start ? 32'h0000_0001 : 32'h0000_00EE;
      datab  = 32'h0;
      clk_en = !(stall_len > 0 && i >= stall_at && i < stall_at + stall_len);
      tick();
      if (lcd_enable === 1'b1) begin
        e_high++;
        if (e_rise < 0) e_rise = i;
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx    = i;
          res_at_done = result;
        end
      end
      if (lcd_data !== b || lcd_rs !== rs) bad_data++;
    end
    start  = 1'b0;
    clk_en = 1'b1;
    check({tag, " data_stable"}, 32'(bad_data), 32'd0);
    check({tag, " rw_low"},      32'(bad_rw),   32'd0);
    check({tag, " e_rise"},      32'(e_rise),   32'd2);
    check({tag, " e_high"},      32'(e_high),   32'(exp_ehigh));
    check({tag, " done_at"},     32'(done_idx), 32'(exp_done));
    check({tag, " done_cnt"},    32'(done_cnt), 32'd1);
    check({tag, " result"},      res_at_done,   {23'd0, rs, b});
  endtask

  initial begin
    int done_seen;
    reset  = 1'b0;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = '0;
    datab  = '0;
    tick();
    tick();
    check("rst done",   32'(done),       32'd0);
    check("rst enable", 32'(lcd_enable), 32'd0);
    check("rst rs",     32'(lcd_rs),     32'd0);
    check("rst rw",     32'(lcd_rw),     32'd0);
    check("rst data",   32'(lcd_data),   32'd0);
    check("rst result", result,          32'd0);
    reset = 1'b1;
    tick();

    // Latency S+P+H+W edges after the sampling edge: 15 short, 27 long.
    run_write("data41",  8'h41, 1'b1, 15, 4, 0, 0, 0, 0);
    run_write("clr01",   8'h01, 1'b0, 27, 4, 0, 0, 0, 0);
    run_write("home02",  8'h02, 1'b0, 27, 4, 0, 0, 0, 0);
    run_write("char01",  8'h01, 1'b1, 15, 4, 0, 0, 0, 0);
    run_write("cmd0C",   8'h0C, 1'b0, 15, 4, 0, 0, 0, 0);
    // Extra starts (byte 0x01, RS=0) during PULSE (edge 4) and WAIT (edge 10).
    run_write("busy48",  8'h48, 1'b1, 15, 4, 4, 10, 0, 0);
    // clk_en low for edges 4..8 inside PULSE on a long-wait command.
    run_write("stall03", 8'h03, 1'b0, 32, 9, 0, 0, 4, 5);

    // Start while clk_en is low in IDLE must not launch a write.
    clk_en = 1'b0;
    start  = 1'b1;
    dataa  = 32'h77;
    datab  = 32'h1;
    tick();
    tick();
    tick();
    clk_en = 1'b1;
    start  = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1 || lcd_enable === 1'b1) done_seen++;
    end
    check("idle_stall data",     32'(lcd_data), 32'h03);
    check("idle_stall rs",       32'(lcd_rs),   32'd0);
    check("idle_stall activity", 32'(done_seen), 32'd0);

    // Reset in WAIT (edge 10 after start) clears outputs and suppresses done.
    start = 1'b1;
    dataa = 32'h5A;
    datab = 32'h1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    check("wrst done",   32'(done),       32'd0);
    check("wrst enable", 32'(lcd_enable), 32'd0);
    check("wrst rs",     32'(lcd_rs),     32'd0);
    check("wrst data",   32'(lcd_data),   32'd0);
    check("wrst result", result,          32'd0);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done === 1'b1 || lcd_enable === 1'b1) done_seen++;
    end
    check("wrst no_done", 32'(done_seen), 32'd0);
    run_write("post30", 8'h30, 1'b0, 15, 4, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
